// File: rtl/subband_serializer.sv
// Ping-pong collector for the analysis filterbank: captures a full set of subband
// samples on each frame strobe and streams them out one band per beat.
module subband_serializer #(
  parameter int NUM_BANDS = 16,
  parameter int DATA_W    = 35,
  parameter int BAND_W    = 4,
  parameter int CNT_W     = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic                        frame_valid,
  input  logic [NUM_BANDS*DATA_W-1:0] band_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [BAND_W-1:0]           out_band,
  output logic                        out_last,
  output logic                        overrun,
  output logic [CNT_W-1:0]            drop_count,
  input  logic                        overrun_clr,
  output logic                        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [BAND_W-1:0] LAST_IDX = BAND_W'(NUM_BANDS - 1);

  state_t                        state_q, state_d;
  logic [BAND_W-1:0]             idx_q, idx_d;
  logic                          rp_q, rp_d, wp_q, wp_d;
  logic [1:0]                    full_q, full_d;
  logic [NUM_BANDS*DATA_W-1:0]   bank_q [2];
  logic [NUM_BANDS*DATA_W-1:0]   bank_d [2];
  logic                          overrun_q, overrun_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic xfer, last_xfer, wp_free, capture, drop;

  // Handshake: a beat moves when out_valid && out_ready on an enabled cycle; while
  // out_valid is high and out_ready low, data/band/last hold and out_valid stays high.
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = out_valid ? bank_q[rp_q][idx_q*DATA_W +: DATA_W] : '0;
  assign out_band   = idx_q;
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign overrun    = overrun_q;
  assign drop_count = cnt_q;
  assign dbg_state  = state_q;

  always_comb begin
    xfer      = out_valid && out_ready;
    last_xfer = xfer && (idx_q == LAST_IDX);
    // A bank freed by the final beat is reusable in the same cycle.
    wp_free   = !full_q[wp_q] || (last_xfer && (rp_q == wp_q));
    capture   = frame_valid && wp_free;
    drop      = frame_valid && !wp_free;

    state_d   = state_q;
    idx_d     = idx_q;
    rp_d      = rp_q;
    wp_d      = wp_q;
    full_d    = full_q;
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    overrun_d = overrun_q;
    cnt_d     = cnt_q;

    if (last_xfer) full_d[rp_q] = 1'b0;
    if (capture) begin
      bank_d[wp_q] = band_in;
      full_d[wp_q] = 1'b1;
      wp_d         = !wp_q;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (full_d[rp_q]) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_xfer) begin
          idx_d = '0;
          rp_d  = !rp_q;
          if (!full_d[!rp_q]) state_d = S_IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (overrun_clr) begin
      overrun_d = 1'b0;
      cnt_d     = '0;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (overrun_clr)                  cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != {CNT_W{1'b1}})  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rp_q      <= 1'b0;
      wp_q      <= 1'b0;
      full_q    <= '0;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      full_q    <= full_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_subband_serializer.sv
// Directed bench for subband_serializer: framing, backpressure, ping-pong,
// overrun/saturation, async reset and clock-enable freeze.
module tb_subband_serializer;

  localparam int NB = 16;
  localparam int DW = 35;
  localparam int BW = 4;
  localparam int CW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              clk_enable;
  logic              frame_valid;
  logic [NB*DW-1:0]  band_in;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [BW-1:0]     out_band;
  logic              out_last;
  logic              overrun;
  logic [CW-1:0]     drop_count;
  logic              overrun_clr;
  logic              dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  subband_serializer #(.NUM_BANDS(NB), .DATA_W(DW), .BAND_W(BW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .clk_enable(clk_enable), .frame_valid(frame_valid),
    .band_in(band_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_band(out_band), .out_last(out_last), .overrun(overrun), .drop_count(drop_count),
    .overrun_clr(overrun_clr), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fval(input int base, input int k);
    return (DW'(base) << 8) | DW'(k + 1);
  endfunction

  task automatic load_frame(input int base);
    for (int k = 0; k < NB; k++) band_in[k*DW +: DW] = fval(base, k);
  endtask

  task automatic chk_beat(input string tag, input int base, input int band);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_band"},  64'(out_band),  64'(band));
    chk({tag, "_data"},  64'(out_data),  64'(fval(base, band)));
    chk({tag, "_last"},  64'(out_last),  64'(band == NB - 1));
  endtask

  // Drains n beats starting at band 'first' with out_ready held high.
  task automatic drain(input string tag, input int base, input int first, input int n);
    out_ready = 1'b1;
    for (int j = 0; j < n; j++) begin
      chk_beat(tag, base, first + j);
      tick();
    end
  endtask

  task automatic pulse_frame(input int base);
    load_frame(base);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  initial begin
    int idx;
    reset = 1'b0; clk_enable = 1'b1; frame_valid = 1'b0; band_in = '0;
    out_ready = 1'b0; overrun_clr = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_band",  64'(out_band),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_ovr",   64'(overrun),   64'd0);
    chk("rst_cnt",   64'(drop_count), 64'd0);
    reset = 1'b1;
    repeat (3) tick();

    // Single frame: band k carries k+1, one-cycle latency, 16 beats then idle.
    out_ready = 1'b1;
    pulse_frame(0);
    drain("single", 0, 0, NB);
    chk("single_idle", 64'(out_valid), 64'd0);

    // Backpressure with out_ready = 1,0,0,1,0,0,...
    pulse_frame('h4000000);
    idx = 0;
    for (int c = 0; c < 80 && idx < NB; c++) begin
      out_ready = (c % 3 == 0);
      chk_beat("bp", 'h4000000, idx);
      if (out_ready) idx++;
      tick();
    end
    chk("bp_count", 64'(idx), 64'(NB));
    chk("bp_idle",  64'(out_valid), 64'd0);

    // Back-to-back frames: Y arrives 5 cycles after X, 32 beats without a bubble.
    out_ready = 1'b1;
    pulse_frame('h100);
    for (int t = 1; t <= 2 * NB; t++) begin
      if (t == 5) begin load_frame('h200); frame_valid = 1'b1; end
      else frame_valid = 1'b0;
      chk_beat("b2b", (t - 1 < NB) ? 'h100 : 'h200, (t - 1) % NB);
      tick();
    end
    frame_valid = 1'b0;
    chk("b2b_idle", 64'(out_valid), 64'd0);

    // Overrun: third frame with both banks full is dropped.
    out_ready = 1'b0;
    pulse_frame('h11); tick();
    pulse_frame('h22); tick();
    pulse_frame('h33); tick();
    chk("ovr_flag", 64'(overrun),    64'd1);
    chk("ovr_cnt",  64'(drop_count), 64'd1);
    chk_beat("ovr_hold", 'h11, 0);
    drain("ovr_f1", 'h11, 0, NB);
    drain("ovr_f2", 'h22, 0, NB);
    chk("ovr_idle", 64'(out_valid), 64'd0);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("clr_flag", 64'(overrun),    64'd0);
    chk("clr_cnt",  64'(drop_count), 64'd0);

    // Frame arriving on the last-beat handshake takes the freed bank.
    out_ready = 1'b0;
    pulse_frame('h44);
    pulse_frame('h55);
    drain("sc_f1", 'h44, 0, NB - 1);
    chk_beat("sc_last", 'h44, NB - 1);
    load_frame('h66); frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("sc_cnt", 64'(drop_count), 64'd0);
    chk("sc_ovr", 64'(overrun),    64'd0);
    drain("sc_f2", 'h55, 0, NB);
    drain("sc_f3", 'h66, 0, NB);
    chk("sc_idle", 64'(out_valid), 64'd0);

    // Saturation: 300 drops clamp at 255; clear and drop together leaves 1.
    out_ready = 1'b0;
    pulse_frame('h77);
    pulse_frame('h78);
    load_frame('h79); frame_valid = 1'b1;
    repeat (300) tick();
    frame_valid = 1'b0;
    chk("sat_cnt", 64'(drop_count), 64'd255);
    chk("sat_ovr", 64'(overrun),    64'd1);
    overrun_clr = 1'b1; frame_valid = 1'b1;
    tick();
    overrun_clr = 1'b0; frame_valid = 1'b0;
    chk("clrdrop_cnt", 64'(drop_count), 64'd1);
    chk("clrdrop_ovr", 64'(overrun),    64'd1);
    drain("sat_f1", 'h77, 0, NB);
    drain("sat_f2", 'h78, 0, NB);
    chk("sat_idle", 64'(out_valid), 64'd0);

    // Async reset while band 7 is on the bus.
    pulse_frame('h88);
    drain("ar", 'h88, 0, 7);
    chk_beat("ar_b7", 'h88, 7);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid),  64'd0);
    chk("ar_cnt",   64'(drop_count), 64'd0);
    chk("ar_ovr",   64'(overrun),    64'd0);
    #1 reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("ar_quiet", 64'(out_valid), 64'd0);
    end

    // Clock-enable freeze in the middle of a stream.
    pulse_frame('h99);
    drain("ce_pre", 'h99, 0, 5);
    clk_enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk_beat("ce_frz", 'h99, 5);
      tick();
    end
    clk_enable = 1'b1;
    drain("ce_post", 'h99, 5, NB - 5);
    chk("ce_idle", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
